// File: rtl/writeback_stage_if.sv
// ============================================================================
// Module      : writeback_stage_if
// Description : MEM-stage to write-back bundle: captured instruction fields in,
//               register-file and fetch-PC results out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface writeback_stage_if #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 32,
    parameter int CNTWIDTH = 64
);
    logic                valid_i;
    logic                stall_i;
    logic                flush_i;
    logic [AWIDTH-1:0]   pc_i;
    logic [DWIDTH-1:0]   alu_res_i;
    logic [DWIDTH-1:0]   memory_data_i;
    logic [1:0]          wbsel_i;
    logic [2:0]          funct3_i;
    logic [4:0]          rd_i;
    logic                regwren_i;
    logic                brtaken_i;

    logic [DWIDTH-1:0]   writeback_data_o;
    logic [4:0]          rd_o;
    logic                regwren_o;
    logic                valid_o;
    logic [AWIDTH-1:0]   next_pc_o;
    logic                redirect_o;
    logic [CNTWIDTH-1:0] instret_o;

    // MEM stage side: presents the instruction, observes the results.
    modport master (
        output valid_i, stall_i, flush_i, pc_i, alu_res_i, memory_data_i,
               wbsel_i, funct3_i, rd_i, regwren_i, brtaken_i,
        input  writeback_data_o, rd_o, regwren_o, valid_o, next_pc_o,
               redirect_o, instret_o
    );

    // Write-back stage side.
    modport slave (
        input  valid_i, stall_i, flush_i, pc_i, alu_res_i, memory_data_i,
               wbsel_i, funct3_i, rd_i, regwren_i, brtaken_i,
        output writeback_data_o, rd_o, regwren_o, valid_o, next_pc_o,
               redirect_o, instret_o
    );
endinterface

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
// Module      : writeback_stage
// Description : Registered write-back stage: load extraction, link address,
//               write gating, next-PC/redirect and retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_stage #(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = 32,
    parameter int                CNTWIDTH = 64,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(32'h0100_0000)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    writeback_stage_if.slave   bus
);

    localparam logic [1:0] c_wb_alu = 2'd0;
    localparam logic [1:0] c_wb_mem = 2'd1;
    localparam logic [1:0] c_wb_pc  = 2'd2;
    localparam logic [1:0] c_wb_off = 2'd3;

    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [AWIDTH-1:0] w_pc_plus4;
    logic [AWIDTH-1:0] w_alu_addr;
    logic [DWIDTH-1:0] w_link;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DWIDTH-1:0] w_load;
    logic [DWIDTH-1:0] w_sel_data;
    logic              w_wren;
    logic [AWIDTH-1:0] w_target;

    assign w_pc_plus4 = bus.pc_i + AWIDTH'(4);

    // Link address is resized to the data width; the target address to AWIDTH.
    generate
        if (DWIDTH > AWIDTH) begin : g_link_zext
            assign w_link     = {{(DWIDTH-AWIDTH){1'b0}}, w_pc_plus4};
            assign w_alu_addr = bus.alu_res_i[AWIDTH-1:0];
        end else if (DWIDTH == AWIDTH) begin : g_link_same
            assign w_link     = w_pc_plus4;
            assign w_alu_addr = bus.alu_res_i;
        end else begin : g_link_trunc
            assign w_link     = w_pc_plus4[DWIDTH-1:0];
            assign w_alu_addr = {{(AWIDTH-DWIDTH){1'b0}}, bus.alu_res_i};
        end
    endgenerate

    assign w_target = {w_alu_addr[AWIDTH-1:1], 1'b0};

    always_comb begin
        w_byte = 8'h00;
        case (bus.alu_res_i[1:0])
            2'd0:    w_byte = bus.memory_data_i[7:0];
            2'd1:    w_byte = bus.memory_data_i[15:8];
            2'd2:    w_byte = bus.memory_data_i[23:16];
            default: w_byte = bus.memory_data_i[31:24];
        endcase
    end

    // Halfword selection deliberately ignores the low offset bit.
    assign w_half = bus.alu_res_i[1] ? bus.memory_data_i[31:16]
                                     : bus.memory_data_i[15:0];

    always_comb begin
        w_load = bus.memory_data_i;
        case (bus.funct3_i)
            c_f3_lb:  w_load = {{(DWIDTH-8){w_byte[7]}}, w_byte};
            c_f3_lbu: w_load = {{(DWIDTH-8){1'b0}}, w_byte};
            c_f3_lh:  w_load = {{(DWIDTH-16){w_half[15]}}, w_half};
            c_f3_lhu: w_load = {{(DWIDTH-16){1'b0}}, w_half};
            default:  w_load = bus.memory_data_i;
        endcase
    end

    always_comb begin
        w_sel_data = '0;
        case (bus.wbsel_i)
            c_wb_alu: w_sel_data = bus.alu_res_i;
            c_wb_mem: w_sel_data = w_load;
            c_wb_pc:  w_sel_data = w_link;
            default:  w_sel_data = '0;
        endcase
    end

    assign w_wren = bus.regwren_i & (bus.rd_i != 5'd0) & (bus.wbsel_i != c_wb_off);

    // ------------------------------------------------------------------
    // Register stage
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0]   wb_data_q,  wb_data_d;
    logic [4:0]          rd_q,       rd_d;
    logic                regwren_q,  regwren_d;
    logic                valid_q,    valid_d;
    logic [AWIDTH-1:0]   next_pc_q,  next_pc_d;
    logic                redirect_q, redirect_d;
    logic [CNTWIDTH-1:0] instret_q,  instret_d;

    // Flush beats stall; a stall freezes everything including redirect.
    always_comb begin
        wb_data_d  = wb_data_q;
        rd_d       = rd_q;
        regwren_d  = regwren_q;
        valid_d    = valid_q;
        next_pc_d  = next_pc_q;
        redirect_d = redirect_q;
        instret_d  = instret_q;
        if (bus.flush_i) begin
            valid_d    = 1'b0;
            regwren_d  = 1'b0;
            redirect_d = 1'b0;
        end else if (bus.stall_i) begin
            valid_d    = valid_q;
        end else if (bus.valid_i) begin
            wb_data_d  = w_sel_data;
            rd_d       = bus.rd_i;
            regwren_d  = w_wren;
            valid_d    = 1'b1;
            next_pc_d  = bus.brtaken_i ? w_target : w_pc_plus4;
            redirect_d = bus.brtaken_i;
            instret_d  = instret_q + CNTWIDTH'(1);
        end else begin
            valid_d    = 1'b0;
            regwren_d  = 1'b0;
            redirect_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data_q  <= '0;
            rd_q       <= 5'd0;
            regwren_q  <= 1'b0;
            valid_q    <= 1'b0;
            next_pc_q  <= RESET_PC;
            redirect_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            wb_data_q  <= wb_data_d;
            rd_q       <= rd_d;
            regwren_q  <= regwren_d;
            valid_q    <= valid_d;
            next_pc_q  <= next_pc_d;
            redirect_q <= redirect_d;
            instret_q  <= instret_d;
        end
    end

    assign bus.writeback_data_o = wb_data_q;
    assign bus.rd_o             = rd_q;
    assign bus.regwren_o        = regwren_q;
    assign bus.valid_o          = valid_q;
    assign bus.next_pc_o        = next_pc_q;
    assign bus.redirect_o       = redirect_q;
    assign bus.instret_o        = instret_q;

endmodule

`default_nettype wire
